sync_frame_window_gen: RTL and testbench

- Parametrised frame/row sync generator for the camera capture path, sitting between the sensor sync inputs and the frame-buffer write logic.
- Delays the row sync by a programmable number of clocks.
- Opens a frame window (fsync_out) after a programmable number of skipped rows and holds it for a programmable number of active rows.
- Everything runs in one clock domain; there is no clocking on sync edges.

---
 rtl/sync_pkg.sv | 20 ++
 rtl/sync_delay_line.sv | 37 +++
 rtl/sync_frame_window_gen.sv | 174 +++++++++++++++++
 tb/tb_sync_frame_window_gen.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// sync_pkg: state encoding, default geometry and a counter-width helper
// shared by the frame/row sync generator.
package sync_pkg;

  localparam int unsigned ROW_BITS_DEF    = 10;
  localparam int unsigned ACTIVE_ROWS_DEF = 240;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    ACTIVE,
    DONE
  } sync_state_e;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH-stage shift register with async active-low reset.
// Exposes the last tap and the tap one stage before it (the input itself
// when DEPTH is 1) so callers can see edges one cycle early.
module sync_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_last,
  output logic [WIDTH-1:0] o_prev
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  // Shift chain: stage 0 captures the input, each later stage its predecessor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_last = r_sr[DEPTH-1];

  generate
    if (DEPTH > 1) begin : g_prev_tap
      assign o_prev = r_sr[DEPTH-2];
    end else begin : g_prev_in
      assign o_prev = i_d;
    end
  endgenerate

endmodule

// File: rtl/sync_frame_window_gen.sv
// sync_frame_window_gen: delays row sync by PIPE_DELAY clocks and opens a
// frame window after ROW_SKIP rows for ACTIVE_ROWS rows.
// Optional macro SYNC_RUNTIME_CFG_EN adds per-frame skip/row-count inputs
// sampled at frame start.
module sync_frame_window_gen
  import sync_pkg::*;
#(
  parameter int unsigned ROW_BITS    = ROW_BITS_DEF,
  parameter int unsigned PIPE_DELAY  = 2,
  parameter int unsigned ROW_SKIP    = 2,
  parameter int unsigned ACTIVE_ROWS = ACTIVE_ROWS_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                vsync_in,
  input  logic                rsync_in,
  output logic                rsync_out,
  output logic                fsync_out,
  output logic [ROW_BITS-1:0] row_idx,
  output logic                frame_start,
  output logic                frame_done,
  output logic                err_short
`ifdef SYNC_RUNTIME_CFG_EN
  ,
  input  logic [ROW_BITS-1:0] row_skip_cfg,
  input  logic [ROW_BITS-1:0] active_rows_cfg
`endif
);

`ifdef SYNC_RUNTIME_CFG_EN
  localparam int unsigned SKIP_W = ROW_BITS;
`else
  localparam int unsigned SKIP_W = cnt_width(ROW_SKIP);
`endif

  logic w_v_last, w_v_prev, w_r_last, w_r_prev;
  logic w_v_fall, w_v_rise, w_r_fall, w_r_rise;

  logic [SKIP_W-1:0]   w_skip_tgt;
  logic [ROW_BITS-1:0] w_last_row;

  sync_state_e         r_state, w_state_nxt;
  logic [SKIP_W-1:0]   r_skip_cnt, w_skip_nxt;
  logic [ROW_BITS-1:0] r_row_idx, w_row_nxt;
  logic                r_fsync, w_fsync_nxt;
  logic                r_fstart, w_fstart_nxt;
  logic                r_fdone, w_fdone_nxt;
  logic                r_err, w_err_nxt;

  sync_delay_line #(.WIDTH(1), .DEPTH(PIPE_DELAY)) u_vsync_dly (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_d    (vsync_in),
    .o_last (w_v_last),
    .o_prev (w_v_prev)
  );

  sync_delay_line #(.WIDTH(1), .DEPTH(PIPE_DELAY)) u_rsync_dly (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_d    (rsync_in),
    .o_last (w_r_last),
    .o_prev (w_r_prev)
  );

  // Strobes fire the cycle before the delayed signal changes, so registered
  // outputs driven from them switch on the same edge as rsync_out.
  assign w_v_fall = w_v_last & ~w_v_prev;
  assign w_v_rise = ~w_v_last & w_v_prev;
  assign w_r_fall = w_r_last & ~w_r_prev;
  assign w_r_rise = ~w_r_last & w_r_prev;

`ifdef SYNC_RUNTIME_CFG_EN
  logic [SKIP_W-1:0]   r_skip_tgt;
  logic [ROW_BITS-1:0] r_last_row;

  // Latch this frame's geometry at frame start; a zero row count means one row
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_skip_tgt <= SKIP_W'(ROW_SKIP);
      r_last_row <= ROW_BITS'(ACTIVE_ROWS - 1);
    end else if (w_fstart_nxt) begin
      r_skip_tgt <= row_skip_cfg;
      r_last_row <= (active_rows_cfg == '0) ? '0 : active_rows_cfg - ROW_BITS'(1);
    end
  end

  assign w_skip_tgt = r_skip_tgt;
  assign w_last_row = r_last_row;
`else
  assign w_skip_tgt = SKIP_W'(ROW_SKIP);
  assign w_last_row = ROW_BITS'(ACTIVE_ROWS - 1);
`endif

  // State, counters and output pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_skip_cnt <= '0;
      r_row_idx  <= '0;
      r_fsync    <= 1'b0;
      r_fstart   <= 1'b0;
      r_fdone    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_skip_cnt <= w_skip_nxt;
      r_row_idx  <= w_row_nxt;
      r_fsync    <= w_fsync_nxt;
      r_fstart   <= w_fstart_nxt;
      r_fdone    <= w_fdone_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Next-state logic; vsync edges take priority over row edges in every state
  always_comb begin
    w_state_nxt  = r_state;
    w_skip_nxt   = r_skip_cnt;
    w_row_nxt    = r_row_idx;
    w_fsync_nxt  = r_fsync;
    w_fstart_nxt = 1'b0;
    w_fdone_nxt  = 1'b0;
    w_err_nxt    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_v_fall) begin
          w_fstart_nxt = 1'b1;
          w_skip_nxt   = '0;
          w_row_nxt    = '0;
          w_state_nxt  = SKIP;
        end
      end
      SKIP: begin
        if (w_v_rise) begin
          w_state_nxt = IDLE;
        end else if (w_r_rise && (r_skip_cnt >= w_skip_tgt)) begin
          w_fsync_nxt = 1'b1;
          w_row_nxt   = '0;
          w_state_nxt = ACTIVE;
        end else if (w_r_fall && (r_skip_cnt < w_skip_tgt)) begin
          w_skip_nxt = r_skip_cnt + SKIP_W'(1);
        end
      end
      ACTIVE: begin
        if (w_v_rise) begin
          w_fsync_nxt = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_r_fall) begin
          if (r_row_idx >= w_last_row) begin
            w_fsync_nxt = 1'b0;
            w_fdone_nxt = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_row_nxt = r_row_idx + ROW_BITS'(1);
          end
        end
      end
      DONE: begin
        if (w_v_rise) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign rsync_out   = w_r_last;
  assign fsync_out   = r_fsync;
  assign row_idx     = r_row_idx;
  assign frame_start = r_fstart;
  assign frame_done  = r_fdone;
  assign err_short   = r_err;

endmodule

// File: tb/tb_sync_frame_window_gen.sv
// Directed bench for sync_frame_window_gen: defaults instance, PIPE_DELAY=5
// instance and ROW_SKIP=0/ACTIVE_ROWS=1 instance driven from shared syncs.
`timescale 1ns/1ps
module tb_sync_frame_window_gen;

  localparam int HI = 6;
  localparam int LO = 4;

  logic clk = 1'b0;
  logic reset_n, vsync_in, rsync_in;

  logic       rs_out, fs_out, fstart, fdone, ferr;
  logic [9:0] ridx;
  logic       d5_rs, d5_fs, d5_fstart, d5_fdone, d5_err;
  logic [9:0] d5_ridx;
  logic       b_rs, b_fs, b_fstart, b_fdone, b_err;
  logic [9:0] b_ridx;
`ifdef SYNC_RUNTIME_CFG_EN
  logic [9:0] skip_cfg, rows_cfg;
`endif

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // monitor state
  int m_rr = 0, m_rf = 0, m_done = 0, m_err = 0;
  int m_fs_rise_at = 0, m_fs_fall_at = 0;
  int b_done = 0, b_rise_at = 0, b_fall_at = 0;
  bit m_rise_al, m_fall_al, m_rs_q, m_fs_q, b_fs_q;

  // frame-start snapshots
  int b0_rr, b0_rf, b0_done, b0_err, b0_bdone;

  logic [7:0] hist;
  int bad5, bad2;

  always #5 clk = ~clk;

  sync_frame_window_gen #(.ROW_BITS(10), .PIPE_DELAY(2), .ROW_SKIP(2), .ACTIVE_ROWS(240)) u_dut (
    .clk(clk), .reset_n(reset_n), .vsync_in(vsync_in), .rsync_in(rsync_in),
    .rsync_out(rs_out), .fsync_out(fs_out), .row_idx(ridx),
    .frame_start(fstart), .frame_done(fdone), .err_short(ferr)
`ifdef SYNC_RUNTIME_CFG_EN
    , .row_skip_cfg(skip_cfg), .active_rows_cfg(rows_cfg)
`endif
  );

  sync_frame_window_gen #(.ROW_BITS(10), .PIPE_DELAY(5), .ROW_SKIP(2), .ACTIVE_ROWS(240)) u_dly5 (
    .clk(clk), .reset_n(reset_n), .vsync_in(vsync_in), .rsync_in(rsync_in),
    .rsync_out(d5_rs), .fsync_out(d5_fs), .row_idx(d5_ridx),
    .frame_start(d5_fstart), .frame_done(d5_fdone), .err_short(d5_err)
`ifdef SYNC_RUNTIME_CFG_EN
    , .row_skip_cfg(10'd2), .active_rows_cfg(10'd240)
`endif
  );

  sync_frame_window_gen #(.ROW_BITS(10), .PIPE_DELAY(2), .ROW_SKIP(0), .ACTIVE_ROWS(1)) u_bnd (
    .clk(clk), .reset_n(reset_n), .vsync_in(vsync_in), .rsync_in(rsync_in),
    .rsync_out(b_rs), .fsync_out(b_fs), .row_idx(b_ridx),
    .frame_start(b_fstart), .frame_done(b_fdone), .err_short(b_err)
`ifdef SYNC_RUNTIME_CFG_EN
    , .row_skip_cfg(10'd0), .active_rows_cfg(10'd1)
`endif
  );

  // Edge bookkeeping sampled on the falling clock edge
  always @(negedge clk) begin
    if (rs_out && !m_rs_q) m_rr++;
    if (!rs_out && m_rs_q) m_rf++;
    if (fs_out && !m_fs_q) begin m_fs_rise_at = m_rr; m_rise_al = rs_out && !m_rs_q; end
    if (!fs_out && m_fs_q) begin m_fs_fall_at = m_rf; m_fall_al = !rs_out && m_rs_q; end
    if (b_fs && !b_fs_q) b_rise_at = m_rr;
    if (!b_fs && b_fs_q) b_fall_at = m_rf;
    if (fdone === 1'b1) m_done++;
    if (ferr === 1'b1) m_err++;
    if (b_fdone === 1'b1) b_done++;
    m_rs_q = rs_out; m_fs_q = fs_out; b_fs_q = b_fs;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rows(input int n);
    for (int i = 0; i < n; i++) begin
      rsync_in = 1'b1; repeat (HI) cyc();
      rsync_in = 1'b0; repeat (LO) cyc();
    end
  endtask

  task automatic vgap();
    vsync_in = 1'b1;
    rsync_in = 1'b0;
    repeat (8) cyc();
  endtask

  task automatic frame_fall();
    b0_rr = m_rr; b0_rf = m_rf; b0_done = m_done; b0_err = m_err; b0_bdone = b_done;
    vsync_in = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int op, input int cl, input int idx, input int b_row);
    check({tag, ".open_row"},      m_fs_rise_at - b0_rr, op);
    check({tag, ".open_aligned"},  m_rise_al, 1);
    check({tag, ".close_row"},     m_fs_fall_at - b0_rf, cl);
    check({tag, ".close_aligned"}, m_fall_al, 1);
    check({tag, ".done_pulses"},   m_done - b0_done, 1);
    check({tag, ".err_pulses"},    m_err - b0_err, 0);
    check({tag, ".row_idx"},       ridx, idx);
    check({tag, ".fsync_closed"},  fs_out, 0);
    check({tag, ".bnd_open_row"},  b_rise_at - b0_rr, b_row);
    check({tag, ".bnd_close_row"}, b_fall_at - b0_rf, b_row);
    check({tag, ".bnd_done"},      b_done - b0_bdone, 1);
    check({tag, ".bnd_row_idx"},   b_ridx, 0);
  endtask

  initial begin
    reset_n  = 1'b0;
    vsync_in = 1'b0;
    rsync_in = 1'b0;
`ifdef SYNC_RUNTIME_CFG_EN
    skip_cfg = 10'd2;
    rows_cfg = 10'd240;
`endif
    for (int i = 0; i < 5; i++) begin
      cyc();
      vsync_in = !vsync_in;
      rsync_in = i[0];
    end
    check("rst.rsync_out",   rs_out, 0);
    check("rst.fsync_out",   fs_out, 0);
    check("rst.row_idx",     ridx, 0);
    check("rst.frame_start", fstart, 0);
    check("rst.frame_done",  fdone, 0);
    check("rst.err_short",   ferr, 0);
    check("rst.dly5_all",    {d5_rs, d5_fs, d5_fstart, d5_fdone, d5_err, d5_ridx}, 0);
    check("rst.bnd_all",     {b_rs, b_fs, b_fstart, b_fdone, b_err, b_ridx}, 0);
    reset_n = 1'b1;
    vgap();

    // frame start latency, then nominal frame with two trailing rows
    frame_fall();
    cyc(); check("fstart.lat1", fstart, 0);
    cyc(); check("fstart.lat2", fstart, 1);
    cyc(); check("fstart.lat3", fstart, 0);
    rows(244);
    check_frame("nom", 3, 242, 239, 1);

    // short frame: vsync returns after 100 active rows
    vgap();
    frame_fall();
    repeat (3) cyc();
    rows(102);
    check("short.row_idx",    ridx, 100);
    check("short.fsync_open", fs_out, 1);
    vsync_in = 1'b1;
    cyc(); check("short.fsync_c1", fs_out, 1); check("short.err_c1", ferr, 0);
    cyc(); check("short.fsync_c2", fs_out, 0); check("short.err_c2", ferr, 1);
    cyc(); check("short.err_c3", ferr, 0);
    check("short.done_pulses", m_done - b0_done, 0);
    check("short.err_pulses",  m_err - b0_err, 1);
    check("short.row_idx_hold", ridx, 100);
    vgap();
    frame_fall();
    repeat (3) cyc();
    rows(244);
    check_frame("after_short", 3, 242, 239, 1);

    // vsync fall coincident with a row rise
    vgap();
    frame_fall();
    rows(244);
    check_frame("simul", 3, 242, 239, 2);

    // asynchronous reset in the middle of an active row
    vgap();
    frame_fall();
    repeat (3) cyc();
    rows(10);
    rsync_in = 1'b1;
    repeat (2) cyc();
    check("midrst.pre_fsync", fs_out, 1);
    check("midrst.pre_idx",   ridx, 8);
    #2 reset_n = 1'b0;
    #1;
    check("midrst.fsync",   fs_out, 0);
    check("midrst.row_idx", ridx, 0);
    check("midrst.rsync",   rs_out, 0);
    rsync_in = 1'b0;
    vsync_in = 1'b1;
    repeat (2) cyc();
    reset_n = 1'b1;
    vgap();
    frame_fall();
    repeat (3) cyc();
    rows(244);
    check_frame("post_rst", 3, 242, 239, 1);

`ifdef SYNC_RUNTIME_CFG_EN
    // runtime geometry: change mid-frame, takes effect next frame
    vgap();
    skip_cfg = 10'd4;
    rows_cfg = 10'd10;
    frame_fall();
    repeat (3) cyc();
    rows(5);
    skip_cfg = 10'd1;
    rows_cfg = 10'd20;
    rows(11);
    check_frame("cfg_a", 5, 14, 9, 1);
    vgap();
    frame_fall();
    repeat (3) cyc();
    rows(23);
    check_frame("cfg_b", 2, 21, 19, 1);
`endif

    // random rows against the delay chains
    vgap();
    hist = '0;
    bad5 = 0;
    bad2 = 0;
    for (int n = 0; n < 10000; n++) begin
      cyc();
      if (d5_rs !== hist[4]) bad5++;
      if (rs_out !== hist[1]) bad2++;
      rsync_in = 1'($urandom_range(0, 1));
      hist = {hist[6:0], rsync_in};
    end
    check("dly5.shift", bad5, 0);
    check("dly2.shift", bad2, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
